adder_sum_accum: RTL and testbench

Downstream stage of the ripple-carry adder. It consumes the WIDTH+1-bit adder sum over a valid/ready handshake and accumulates a programmable number of consecutive sums into one block total. It presents the total and a sticky overflow flag on a valid/ready output port. It sits between the rca sum_o and the result sink or checker logic.

---
 rtl/adder_sum_accum.sv | 137 +++++++++++++
 tb/tb_adder_sum_accum.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sum_accum.sv
// Block accumulator behind the ripple-carry adder: sums a programmable number of adder results per block.
// Optional macro ACC_SAT_EN makes the block total saturate on overflow instead of wrapping.
module adder_sum_accum #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sum_valid_i,
  output logic                 sum_ready_o,
  input  logic [WIDTH:0]       sum_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  output logic                 acc_valid_o,
  input  logic                 acc_ready_i,
  output logic [ACC_WIDTH-1:0] acc_o,
  output logic                 acc_ovf_o,
  output logic [CNT_WIDTH:0]   beat_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_HOLD
  } state_e;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH:0]   len_q, len_d;
  logic                 acc_valid_q, acc_valid_d;

  logic                 in_beat;
  logic                 out_beat;
  logic [ACC_WIDTH:0]   sum_ext;
  logic [ACC_WIDTH:0]   add_full;
  logic [ACC_WIDTH-1:0] acc_add;
  logic [CNT_WIDTH:0]   len_in;
  logic [CNT_WIDTH:0]   cnt_inc;

  // Ready depends only on the state register and reset, never on acc_ready_i.
  assign sum_ready_o = !rst_i && (state_q != ST_HOLD);
  assign in_beat     = sum_valid_i && sum_ready_o;
  assign out_beat    = acc_valid_q && acc_ready_i;

  assign sum_ext  = {{(ACC_WIDTH - WIDTH){1'b0}}, sum_i};
  assign add_full = {1'b0, acc_q} + sum_ext;
  assign cnt_inc  = cnt_q + 1'b1;

  // A zero length field encodes the maximum block length 2^CNT_WIDTH.
  assign len_in = (len_i == '0) ? {1'b1, {CNT_WIDTH{1'b0}}} : {1'b0, len_i};

`ifdef ACC_SAT_EN
  // Once saturated, any further nonzero sum carries out again, so the total stays pinned.
  assign acc_add = add_full[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : add_full[ACC_WIDTH-1:0];
`else
  assign acc_add = add_full[ACC_WIDTH-1:0];
`endif

  // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    acc_valid_d = acc_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_beat) begin
          len_d = len_in;
          acc_d = sum_ext[ACC_WIDTH-1:0];
          ovf_d = 1'b0;
          cnt_d = {{CNT_WIDTH{1'b0}}, 1'b1};
          if (len_in == {{CNT_WIDTH{1'b0}}, 1'b1}) begin
            state_d     = ST_HOLD;
            acc_valid_d = 1'b1;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end

      ST_ACCUM: begin
        if (in_beat) begin
          acc_d = acc_add;
          ovf_d = ovf_q | add_full[ACC_WIDTH];
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d     = ST_HOLD;
            acc_valid_d = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (out_beat) begin
          state_d     = ST_IDLE;
          acc_valid_d = 1'b0;
          cnt_d       = '0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        acc_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples the values from before the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      len_q       <= '0;
      acc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      acc_valid_q <= acc_valid_d;
    end
  end

  assign acc_valid_o = acc_valid_q;
  assign acc_o       = acc_q;
  assign acc_ovf_o   = ovf_q;
  assign beat_cnt_o  = cnt_q;

endmodule

// File: tb/tb_adder_sum_accum.sv
// Self-checking bench for adder_sum_accum (WIDTH=8, ACC_WIDTH=10, CNT_WIDTH=4) against a plain-arithmetic block-sum model.
// Expectations follow ACC_SAT_EN when the macro is defined for the build.
module tb_adder_sum_accum;

  localparam int WIDTH     = 8;
  localparam int ACC_WIDTH = 10;
  localparam int CNT_WIDTH = 4;
  localparam int ACC_MAX   = (1 << ACC_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 sum_valid_i = 1'b0;
  logic                 sum_ready_o;
  logic [WIDTH:0]       sum_i = '0;
  logic [CNT_WIDTH-1:0] len_i = '0;
  logic                 acc_valid_o;
  logic                 acc_ready_i = 1'b0;
  logic [ACC_WIDTH-1:0] acc_o;
  logic                 acc_ovf_o;
  logic [CNT_WIDTH:0]   beat_cnt_o;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int pre_errs;
    int cnt_errs;
    int hold_errs;
    bit timeout;
    bit valid_at_end;
    int acc;
    bit ovf;
    int cnt;
    bit ready_in_hold;
    bit valid_after;
    bit ready_after;
    int cnt_after;
    int acc_after;
  } obs_t;

  adder_sum_accum #(
    .WIDTH    (WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .sum_valid_i(sum_valid_i),
    .sum_ready_o(sum_ready_o),
    .sum_i      (sum_i),
    .len_i      (len_i),
    .acc_valid_o(acc_valid_o),
    .acc_ready_i(acc_ready_i),
    .acc_o      (acc_o),
    .acc_ovf_o  (acc_ovf_o),
    .beat_cnt_o (beat_cnt_o)
  );

  always #5 clk = ~clk;

  // Block total from the true integer sum: overflow means the sum does not fit ACC_WIDTH bits.
  function automatic void model(input int sums[$], output int e_acc, output bit e_ovf);
    longint total;
    total = 0;
    foreach (sums[i]) total += sums[i];
    e_ovf = (total > ACC_MAX);
`ifdef ACC_SAT_EN
    e_acc = e_ovf ? ACC_MAX : int'(total);
`else
    e_acc = int'(total % (ACC_MAX + 1));
`endif
  endfunction

  // Drives one block starting at a negedge and records what the DUT shows; tests judge the record.
  task automatic drive_block(input int len_field, input int sums[$], input int gap_pct,
                             input logic [31:0] vmask, input int hold_cycles, output obs_t o);
    int n;
    int beats;
    int cyc;
    bit v;
    n = sums.size();
    beats = 0;
    cyc = 0;
    o = '{default: 0};
    acc_ready_i = 1'b0;
    while (beats < n && cyc < 200) begin
      if (vmask != 0 && cyc < 32) v = vmask[cyc];
      else v = ($urandom_range(99) >= gap_pct);
      sum_valid_i = v;
      sum_i = v ? 9'(sums[beats]) : 9'($urandom);
      len_i = (beats == 0) ? 4'(len_field) : (4'(len_field) ^ 4'hb);
      if (acc_valid_o !== 1'b0 || sum_ready_o !== 1'b1) o.pre_errs++;
      @(negedge clk);
      if (v) begin
        beats++;
        if (beat_cnt_o !== 5'(beats)) o.cnt_errs++;
      end
      cyc++;
    end
    sum_valid_i = 1'b0;
    o.timeout = (beats < n);
    o.valid_at_end = acc_valid_o;
    o.acc = int'(acc_o);
    o.ovf = acc_ovf_o;
    o.cnt = int'(beat_cnt_o);
    o.ready_in_hold = sum_ready_o;
    repeat (hold_cycles) begin
      @(negedge clk);
      if (acc_valid_o !== 1'b1 || int'(acc_o) !== o.acc || acc_ovf_o !== o.ovf || sum_ready_o !== 1'b0)
        o.hold_errs++;
    end
    acc_ready_i = 1'b1;
    @(negedge clk);
    acc_ready_i = 1'b0;
    o.valid_after = acc_valid_o;
    o.ready_after = sum_ready_o;
    o.cnt_after = int'(beat_cnt_o);
    o.acc_after = int'(acc_o);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (sum_ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", sum_ready_o); end
    checks++; if (acc_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", acc_valid_o); end
    checks++; if (acc_o !== '0) begin fails++; $display("FAIL reset_acc: got %0d want 0", acc_o); end
    checks++; if (acc_ovf_o !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", acc_ovf_o); end
    checks++; if (beat_cnt_o !== '0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", beat_cnt_o); end
    rst_i = 1'b0;
    @(negedge clk);
    checks++; if (sum_ready_o !== 1'b1) begin fails++; $display("FAIL idle_ready: got %b want 1", sum_ready_o); end
  endtask

  task automatic test_normal();
    obs_t o;
    drive_block(4, '{10, 20, 30, 40}, 0, 32'h0, 0, o);
    checks++; if (o.timeout || o.pre_errs != 0 || o.cnt_errs != 0) begin fails++; $display("FAIL normal_feed: timeout %b pre %0d cnt %0d want 0 0 0", o.timeout, o.pre_errs, o.cnt_errs); end
    checks++; if (o.valid_at_end !== 1'b1) begin fails++; $display("FAIL normal_latency: valid %b want 1", o.valid_at_end); end
    checks++; if (o.acc !== 100) begin fails++; $display("FAIL normal_acc: got %0d want 100", o.acc); end
    checks++; if (o.ovf !== 1'b0) begin fails++; $display("FAIL normal_ovf: got %b want 0", o.ovf); end
    checks++; if (o.cnt !== 4) begin fails++; $display("FAIL normal_cnt: got %0d want 4", o.cnt); end
    checks++; if (o.valid_after !== 1'b0 || o.ready_after !== 1'b1) begin fails++; $display("FAIL normal_release: valid %b ready %b want 0 1", o.valid_after, o.ready_after); end
    checks++; if (o.cnt_after !== 0 || o.acc_after !== 100) begin fails++; $display("FAIL normal_after: cnt %0d acc %0d want 0 100", o.cnt_after, o.acc_after); end
  endtask

  task automatic test_backpressure();
    obs_t o;
    drive_block(4, '{10, 20, 30, 40}, 0, 32'h0, 5, o);
    checks++; if (o.acc !== 100 || o.hold_errs != 0) begin fails++; $display("FAIL bp_hold: acc %0d hold_errs %0d want 100 0", o.acc, o.hold_errs); end
    checks++; if (o.ready_in_hold !== 1'b0) begin fails++; $display("FAIL bp_ready_hold: got %b want 0", o.ready_in_hold); end
    checks++; if (o.valid_after !== 1'b0 || o.ready_after !== 1'b1) begin fails++; $display("FAIL bp_release: valid %b ready %b want 0 1", o.valid_after, o.ready_after); end
  endtask

  task automatic test_len_edges();
    obs_t o;
    int ones[$];
    drive_block(1, '{511}, 0, 32'h0, 0, o);
    checks++; if (o.valid_at_end !== 1'b1 || o.acc !== 511 || o.cnt !== 1) begin fails++; $display("FAIL len1: valid %b acc %0d cnt %0d want 1 511 1", o.valid_at_end, o.acc, o.cnt); end
    for (int i = 0; i < 16; i++) ones.push_back(1);
    drive_block(0, ones, 0, 32'h0, 1, o);
    checks++; if (o.timeout || o.valid_at_end !== 1'b1 || o.acc !== 16) begin fails++; $display("FAIL len0_acc: valid %b acc %0d want 1 16", o.valid_at_end, o.acc); end
    checks++; if (o.cnt !== 16 || o.cnt_errs != 0 || o.pre_errs != 0) begin fails++; $display("FAIL len0_cnt: cnt %0d cnt_errs %0d pre %0d want 16 0 0", o.cnt, o.cnt_errs, o.pre_errs); end
  endtask

  task automatic test_overflow();
    obs_t o;
    int e_acc;
    bit e_ovf;
    model('{511, 511, 511}, e_acc, e_ovf);
    drive_block(3, '{511, 511, 511}, 0, 32'h0, 2, o);
    checks++; if (o.acc !== e_acc) begin fails++; $display("FAIL ovf_acc: got %0d want %0d", o.acc, e_acc); end
    checks++; if (o.ovf !== e_ovf || o.hold_errs != 0) begin fails++; $display("FAIL ovf_flag: got %b hold_errs %0d want %b 0", o.ovf, o.hold_errs, e_ovf); end
  endtask

  task automatic test_gaps();
    obs_t o;
    drive_block(3, '{5, 7, 9}, 0, 32'b101001, 0, o);
    checks++; if (o.timeout || o.pre_errs != 0 || o.cnt_errs != 0) begin fails++; $display("FAIL gaps_feed: timeout %b pre %0d cnt %0d want 0 0 0", o.timeout, o.pre_errs, o.cnt_errs); end
    checks++; if (o.valid_at_end !== 1'b1 || o.acc !== 21 || o.cnt !== 3) begin fails++; $display("FAIL gaps_acc: valid %b acc %0d cnt %0d want 1 21 3", o.valid_at_end, o.acc, o.cnt); end
  endtask

  task automatic test_reset_mid_block();
    obs_t o;
    @(negedge clk);
    len_i = 4'd4;
    sum_valid_i = 1'b1;
    sum_i = 9'd3;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    #1;
    checks++; if (sum_ready_o !== 1'b0) begin fails++; $display("FAIL rst_mid_ready: got %b want 0", sum_ready_o); end
    @(negedge clk);
    checks++; if (acc_valid_o !== 1'b0 || acc_o !== '0 || acc_ovf_o !== 1'b0 || beat_cnt_o !== '0)
      begin fails++; $display("FAIL rst_mid_outputs: valid %b acc %0d ovf %b cnt %0d want all 0", acc_valid_o, acc_o, acc_ovf_o, beat_cnt_o); end
    rst_i = 1'b0;
    sum_valid_i = 1'b0;
    @(negedge clk);
    drive_block(2, '{3, 4}, 0, 32'h0, 0, o);
    checks++; if (o.valid_at_end !== 1'b1 || o.acc !== 7 || o.cnt !== 2) begin fails++; $display("FAIL rst_mid_next: valid %b acc %0d cnt %0d want 1 7 2", o.valid_at_end, o.acc, o.cnt); end
  endtask

  task automatic test_random();
    obs_t o;
    int sums[$];
    int len_field;
    int n;
    int e_acc;
    bit e_ovf;
    for (int b = 0; b < 20; b++) begin
      sums.delete();
      len_field = $urandom_range(15);
      n = (len_field == 0) ? 16 : len_field;
      for (int i = 0; i < n; i++) sums.push_back($urandom_range(511));
      model(sums, e_acc, e_ovf);
      drive_block(len_field, sums, 30, 32'h0, $urandom_range(3), o);
      checks++;
      if (o.timeout || o.pre_errs != 0 || o.cnt_errs != 0 || o.hold_errs != 0 || o.valid_at_end !== 1'b1 ||
          o.acc !== e_acc || o.ovf !== e_ovf || o.cnt !== n || o.valid_after !== 1'b0 || o.ready_after !== 1'b1) begin
        fails++;
        $display("FAIL rand_block%0d: len %0d acc %0d ovf %b cnt %0d valid %b errs %0d/%0d/%0d want acc %0d ovf %b cnt %0d",
                 b, len_field, o.acc, o.ovf, o.cnt, o.valid_at_end, o.pre_errs, o.cnt_errs, o.hold_errs, e_acc, e_ovf, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_backpressure();
    test_len_edges();
    test_overflow();
    test_gaps();
    test_reset_mid_block();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
